// File: rtl/pix_pkg.sv
// Shared pixel constants for the clamp slice.
// Pixel width/max and colour lane indices.
package pix_pkg;
    localparam int PIX_W = 8;
    localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;
    localparam int R = 0;
    localparam int G = 1;
    localparam int B = 2;
endpackage

// File: rtl/saturate_clamp_if.sv
// Sample bus for saturate_clamp.
// master drives samples/cnt_clr; slave returns clamped pixels, flags, count.
interface saturate_clamp_if
    import pix_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int OUT_W = PIX_W,
    parameter int NCH   = 3,
    parameter int CNT_W = 16
);
    logic                   in_valid;
    logic [NCH*IN_W-1:0]    in_data;
    logic                   cnt_clr;
    logic                   out_valid;
    logic [NCH*OUT_W-1:0]   out_data;
    logic [NCH-1:0]         sat_hi;
    logic [NCH-1:0]         sat_lo;
    logic [CNT_W-1:0]       sat_cnt;

    modport master (
        output in_valid, in_data, cnt_clr,
        input  out_valid, out_data,
        input  sat_hi, sat_lo, sat_cnt
    );

    modport slave (
        input  in_valid, in_data, cnt_clr,
        output out_valid, out_data,
        output sat_hi, sat_lo, sat_cnt
    );
endinterface

// File: rtl/sat_lane.sv
// One lane: combinational clamp of an accumulator slice to pixel range.
// i_x: input word; o_y: clamped pixel; o_hi/o_lo: clamp-to-max/zero flags.
module sat_lane
    import pix_pkg::*;
#(
    parameter int IN_W      = 10,
    parameter int OUT_W     = PIX_W,
    parameter int SIGNED_IN = 0
) (
    input  logic [IN_W-1:0]  i_x,
    output logic [OUT_W-1:0] o_y,
    output logic             o_hi,
    output logic             o_lo
);
    localparam logic [IN_W-1:0] MAX_IN =
        {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic w_neg;
    logic w_over;

    // Once negatives are excluded, an unsigned compare is valid
    // for both modes.
    assign w_neg  = (SIGNED_IN != 0) && i_x[IN_W-1];
    assign w_over = !w_neg && (i_x > MAX_IN);

    always_comb begin
        o_y = i_x[OUT_W-1:0];
        if (w_neg) begin
            o_y = '0;
        end else if (w_over) begin
            o_y = '1;
        end
    end

    assign o_hi = w_over;
    assign o_lo = w_neg;
endmodule

// File: rtl/saturate_clamp.sv
// Registered per-lane clamp of filter accumulator slices to pixel range.
// clk/reset_n plain; bus (slave) carries samples, pixels, flags, count.
module saturate_clamp
    import pix_pkg::*;
#(
    parameter int IN_W      = 10,
    parameter int OUT_W     = PIX_W,
    parameter int NCH       = 3,
    parameter int SIGNED_IN = 0,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    saturate_clamp_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NCH*OUT_W-1:0] w_data;
    logic [NCH-1:0]       w_hi;
    logic [NCH-1:0]       w_lo;
    logic                 w_clamp;

    logic                 r_valid;
    logic [NCH*OUT_W-1:0] r_data;
    logic [NCH-1:0]       r_hi;
    logic [NCH-1:0]       r_lo;
    logic [CNT_W-1:0]     r_cnt;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        sat_lane #(
            .IN_W      (IN_W),
            .OUT_W     (OUT_W),
            .SIGNED_IN (SIGNED_IN)
        ) u_lane (
            .i_x  (bus.in_data[k*IN_W +: IN_W]),
            .o_y  (w_data[k*OUT_W +: OUT_W]),
            .o_hi (w_hi[k]),
            .o_lo (w_lo[k])
        );
    end

    // Several lanes clamping together count as one event.
    assign w_clamp = bus.in_valid && (|(w_hi | w_lo));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_data <= w_data;
                r_hi   <= w_hi;
                r_lo   <= w_lo;
            end
        end
    end

    // Clear wins over increment; count sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_cnt <= '0;
        end else if (w_clamp && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.sat_hi    = r_hi;
    assign bus.sat_lo    = r_lo;
    assign bus.sat_cnt   = r_cnt;
endmodule

// File: tb/tb_saturate_clamp.sv
// Directed bench: unsigned, signed and 4-bit-counter instances of saturate_clamp.
// Same stimulus to all three; hand-computed expectations.
module tb_saturate_clamp;
    import pix_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    saturate_clamp_if #(.CNT_W(16)) ia ();
    saturate_clamp_if #(.CNT_W(16)) is ();
    saturate_clamp_if #(.CNT_W(4))  ic ();

    saturate_clamp #(.SIGNED_IN(0), .CNT_W(16)) u_a (
        .clk(clk), .reset_n(reset_n), .bus(ia));
    saturate_clamp #(.SIGNED_IN(1), .CNT_W(16)) u_s (
        .clk(clk), .reset_n(reset_n), .bus(is));
    saturate_clamp #(.SIGNED_IN(0), .CNT_W(4))  u_c (
        .clk(clk), .reset_n(reset_n), .bus(ic));

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v,
                         input logic [9:0] r,
                         input logic [9:0] g,
                         input logic [9:0] b,
                         input logic clr);
        logic [29:0] d;
        d = 30'd0;
        d[R*10 +: 10] = r;
        d[G*10 +: 10] = g;
        d[B*10 +: 10] = b;
        ia.in_valid = v; ia.in_data = d; ia.cnt_clr = clr;
        is.in_valid = v; is.in_data = d; is.cnt_clr = clr;
        ic.in_valid = v; ic.in_data = d; ic.cnt_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag, input int which);
        if (which == 0) begin
            chk({tag, " a.vld"}, 32'(ia.out_valid), 0);
            chk({tag, " a.dat"}, 32'(ia.out_data), 0);
            chk({tag, " a.hi"},  32'(ia.sat_hi), 0);
            chk({tag, " a.cnt"}, 32'(ia.sat_cnt), 0);
        end else if (which == 1) begin
            chk({tag, " s.vld"}, 32'(is.out_valid), 0);
            chk({tag, " s.dat"}, 32'(is.out_data), 0);
            chk({tag, " s.lo"},  32'(is.sat_lo), 0);
            chk({tag, " s.cnt"}, 32'(is.sat_cnt), 0);
        end else begin
            chk({tag, " c.vld"}, 32'(ic.out_valid), 0);
            chk({tag, " c.cnt"}, 32'(ic.sat_cnt), 0);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b0);
        tick();
        tick();
        chk_zero("reset", 0);
        chk_zero("reset", 1);
        chk_zero("reset", 2);
        reset_n = 1'b1;

        // pass-through
        drive(1'b1, 10'd0, 10'd128, 10'd255, 1'b0);
        tick();
        chk("pass a.vld", 32'(ia.out_valid), 1);
        chk("pass a.dat", 32'(ia.out_data), 32'hFF8000);
        chk("pass a.hi",  32'(ia.sat_hi), 0);
        chk("pass a.cnt", 32'(ia.sat_cnt), 0);
        chk("pass s.dat", 32'(is.out_data), 32'hFF8000);
        chk("pass s.lo",  32'(is.sat_lo), 0);

        // clamp high
        drive(1'b1, 10'd256, 10'd1023, 10'd255, 1'b0);
        tick();
        chk("hi a.dat", 32'(ia.out_data), 32'hFFFFFF);
        chk("hi a.hi",  32'(ia.sat_hi), 32'b011);
        chk("hi a.lo",  32'(ia.sat_lo), 0);
        chk("hi a.cnt", 32'(ia.sat_cnt), 1);
        chk("hi s.dat", 32'(is.out_data), 32'hFF00FF);
        chk("hi s.hi",  32'(is.sat_hi), 32'b001);
        chk("hi s.lo",  32'(is.sat_lo), 32'b010);
        chk("hi s.cnt", 32'(is.sat_cnt), 1);

        // signed vector
        drive(1'b1, 10'h3FF, 10'h1FF, 10'd0, 1'b0);
        tick();
        chk("sgn s.dat", 32'(is.out_data), 32'h00FF00);
        chk("sgn s.lo",  32'(is.sat_lo), 32'b001);
        chk("sgn s.hi",  32'(is.sat_hi), 32'b010);
        chk("sgn s.cnt", 32'(is.sat_cnt), 2);
        chk("sgn a.dat", 32'(ia.out_data), 32'h00FFFF);
        chk("sgn a.hi",  32'(ia.sat_hi), 32'b011);
        chk("sgn a.cnt", 32'(ia.sat_cnt), 2);

        // valid gating
        drive(1'b0, 10'd1023, 10'd1023, 10'd1023, 1'b0);
        tick();
        chk("gate a.vld", 32'(ia.out_valid), 0);
        chk("gate a.dat", 32'(ia.out_data), 32'h00FFFF);
        chk("gate a.hi",  32'(ia.sat_hi), 32'b011);
        chk("gate a.cnt", 32'(ia.sat_cnt), 2);
        chk("gate s.dat", 32'(is.out_data), 32'h00FF00);
        chk("gate s.lo",  32'(is.sat_lo), 32'b001);
        chk("gate s.cnt", 32'(is.sat_cnt), 2);

        // boundary 255 passes, 256 clamps
        drive(1'b1, 10'd255, 10'd256, 10'd1, 1'b0);
        tick();
        chk("bnd a.vld", 32'(ia.out_valid), 1);
        chk("bnd a.dat", 32'(ia.out_data), 32'h01FFFF);
        chk("bnd a.hi",  32'(ia.sat_hi), 32'b010);
        chk("bnd a.cnt", 32'(ia.sat_cnt), 3);
        chk("bnd s.dat", 32'(is.out_data), 32'h01FFFF);
        chk("bnd s.lo",  32'(is.sat_lo), 0);

        // no clamp: counter holds
        drive(1'b1, 10'd1, 10'd2, 10'd3, 1'b0);
        tick();
        chk("nc a.dat", 32'(ia.out_data), 32'h030201);
        chk("nc a.hi",  32'(ia.sat_hi), 0);
        chk("nc a.cnt", 32'(ia.sat_cnt), 3);
        chk("nc c.cnt", 32'(ic.sat_cnt), 3);

        // 20 back-to-back clamps; 4-bit counter sticks at F
        drive(1'b1, 10'd1023, 10'd1023, 10'd1023, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 11) chk("c12 c.cnt", 32'(ic.sat_cnt), 15);
            if (i == 12) chk("c13 c.cnt", 32'(ic.sat_cnt), 15);
        end
        chk("c20 c.cnt", 32'(ic.sat_cnt), 15);
        chk("c20 a.cnt", 32'(ia.sat_cnt), 23);

        // clear beats increment
        drive(1'b1, 10'd1023, 10'd0, 10'd0, 1'b1);
        tick();
        chk("clr c.cnt", 32'(ic.sat_cnt), 0);
        chk("clr a.cnt", 32'(ia.sat_cnt), 0);
        chk("clr a.hi",  32'(ia.sat_hi), 32'b001);
        drive(1'b1, 10'd1023, 10'd0, 10'd0, 1'b0);
        tick();
        chk("inc c.cnt", 32'(ic.sat_cnt), 1);

        // async reset mid-stream
        drive(1'b1, 10'd1023, 10'd1023, 10'd7, 1'b0);
        tick();
        chk("pre a.vld", 32'(ia.out_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("arst", 0);
        chk_zero("arst", 1);
        chk_zero("arst", 2);
        tick();
        chk_zero("held", 0);
        reset_n = 1'b1;

        // first valid after reset
        drive(1'b1, 10'd5, 10'd300, 10'd0, 1'b0);
        tick();
        chk("post a.vld", 32'(ia.out_valid), 1);
        chk("post a.dat", 32'(ia.out_data), 32'h00FF05);
        chk("post a.hi",  32'(ia.sat_hi), 32'b010);
        chk("post a.cnt", 32'(ia.sat_cnt), 1);
        drive(1'b0, 10'd0, 10'd0, 10'd0, 1'b0);
        tick();
        chk("post a.idle", 32'(ia.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
